// File: rtl/axi_s_check_data.sv
// AXI-Stream sink that checks framed counter data {k, ~k}.
// Tracks frame/error counts, sticky error flags and a good-frame link status.
module axi_s_check_data #(
  parameter logic [3:0] P_KEEP      = 4'b1111,
  parameter int         P_FRAME_LEN = 16,
  parameter int         P_OK_FRAMES = 4,
  parameter int         P_BP_EN     = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_axi_s_data,
  input  logic [3:0]  i_axi_s_keep,
  input  logic        i_axi_s_last,
  input  logic        i_axi_s_valid,
  output logic        o_axi_s_ready,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_err_cnt,
  output logic        o_data_err,
  output logic        o_len_err,
  output logic        o_link_ok
);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  localparam logic [15:0] LastIdx = 16'(P_FRAME_LEN - 1);
  localparam logic [7:0]  OkN     = 8'(P_OK_FRAMES);
  localparam logic [31:0] KeepMask = {{8{P_KEEP[3]}}, {8{P_KEEP[2]}},
                                      {8{P_KEEP[1]}}, {8{P_KEEP[0]}}};

  state_t      state_q;
  logic        ready_q;
  logic [15:0] idx_q;
  logic [31:0] frame_cnt_q;
  logic [15:0] err_cnt_q;
  logic        data_err_q;
  logic        len_err_q;
  logic        link_ok_q;
  logic        bad_q;
  logic [7:0]  streak_q;
  logic [7:0]  streak_d;

  logic        acc;
  logic [31:0] exp_data;
  logic        mis;
  logic        mis_full;
  logic        mis_last;
  logic        close;
  logic        len_bad;
  logic        bad;

  assign acc      = i_axi_s_valid & ready_q;
  assign exp_data = {idx_q, ~idx_q};
  assign mis_full = (i_axi_s_data != exp_data) ||
                    (i_axi_s_keep != 4'hF);
  assign mis_last = (((i_axi_s_data ^ exp_data) & KeepMask) != 32'd0) ||
                    (i_axi_s_keep != P_KEEP);

  always_comb begin
    mis      = 1'b0;
    close    = 1'b0;
    len_bad  = 1'b0;
    if (acc) begin
      // Beats past the nominal length are only drained, never compared
      if (state_q != DRAIN) begin
        mis = i_axi_s_last ? mis_last : mis_full;
      end
      unique case (state_q)
        IDLE: begin
          close   = i_axi_s_last;
          len_bad = i_axi_s_last;
        end
        RECV: begin
          close   = i_axi_s_last;
          len_bad = i_axi_s_last ? (idx_q != LastIdx) : (idx_q == LastIdx);
        end
        DRAIN: close = i_axi_s_last;
        default: ;
      endcase
    end
    bad      = bad_q | mis | len_bad;
    streak_d = streak_q;
    if (close) begin
      if (bad) begin
        streak_d = 8'd0;
      end else if (streak_q != OkN) begin
        streak_d = streak_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      idx_q       <= 16'd0;
      frame_cnt_q <= 32'd0;
      err_cnt_q   <= 16'd0;
      data_err_q  <= 1'b0;
      len_err_q   <= 1'b0;
      link_ok_q   <= 1'b0;
      bad_q       <= 1'b0;
      streak_q    <= 8'd0;
    end else begin
      ready_q <= (P_BP_EN != 0) ? ~ready_q : 1'b1;
      if (acc) begin
        data_err_q <= data_err_q | mis;
        len_err_q  <= len_err_q | len_bad;
        bad_q      <= close ? 1'b0 : bad;
        unique case (state_q)
          IDLE: begin
            state_q <= i_axi_s_last ? IDLE : RECV;
            idx_q   <= i_axi_s_last ? 16'd0 : 16'd1;
          end
          RECV: begin
            if (i_axi_s_last) begin
              state_q <= IDLE;
              idx_q   <= 16'd0;
            end else begin
              if (idx_q == LastIdx) state_q <= DRAIN;
              idx_q <= idx_q + 16'd1;
            end
          end
          DRAIN: begin
            if (i_axi_s_last) begin
              state_q <= IDLE;
              idx_q   <= 16'd0;
            end else begin
              idx_q <= idx_q + 16'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
        if (close) begin
          frame_cnt_q <= frame_cnt_q + 32'd1;
          if (bad && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
          end
          streak_q  <= streak_d;
          link_ok_q <= (streak_d == OkN);
        end
      end
    end
  end

  assign o_axi_s_ready = ready_q;
  assign o_frame_cnt   = frame_cnt_q;
  assign o_err_cnt     = err_cnt_q;
  assign o_data_err    = data_err_q;
  assign o_len_err     = len_err_q;
  assign o_link_ok     = link_ok_q;

endmodule

// File: tb/tb_axi_s_check_data.sv
// Bench for axi_s_check_data: frame table, directed corner cases,
// randomized traffic against a frame-level reference model.
module tb_axi_s_check_data;

  localparam int FL = 16;
  localparam int OK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [3:0]  keep;
  logic        last;
  logic        valid;

  logic        r0, r1, r2;
  logic [31:0] f0, f1, f2;
  logic [15:0] e0, e1, e2;
  logic        de0, de1, de2;
  logic        le0, le1, le2;
  logic        l0, l1, l2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_s_check_data dut0 (
    .i_clk(clk), .i_rst(rst), .i_axi_s_data(data), .i_axi_s_keep(keep),
    .i_axi_s_last(last), .i_axi_s_valid(valid), .o_axi_s_ready(r0),
    .o_frame_cnt(f0), .o_err_cnt(e0), .o_data_err(de0),
    .o_len_err(le0), .o_link_ok(l0)
  );

  axi_s_check_data #(.P_KEEP(4'b1000)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_axi_s_data(data), .i_axi_s_keep(keep),
    .i_axi_s_last(last), .i_axi_s_valid(valid), .o_axi_s_ready(r1),
    .o_frame_cnt(f1), .o_err_cnt(e1), .o_data_err(de1),
    .o_len_err(le1), .o_link_ok(l1)
  );

  axi_s_check_data #(.P_BP_EN(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_axi_s_data(data), .i_axi_s_keep(keep),
    .i_axi_s_last(last), .i_axi_s_valid(valid), .o_axi_s_ready(r2),
    .o_frame_cnt(f2), .o_err_cnt(e2), .o_data_err(de2),
    .o_len_err(le2), .o_link_ok(l2)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; valid = 1'b0; last = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] expd(input int k);
    logic [15:0] kk;
    kk = k[15:0];
    return {kk, ~kk};
  endfunction

  task automatic send_frame(input int nb, input int flip,
                            input logic [31:0] fm, input logic [3:0] lk,
                            input bit junk);
    for (int k = 0; k < nb; k++) begin
      data = expd(k);
      if (k == flip) data = data ^ fm;
      last = (k == nb - 1);
      keep = last ? lk : 4'hF;
      if (last && junk) data[23:0] = data[23:0] ^ 24'h5A3C96;
      valid = 1'b1;
      tick();
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  // Frame-level reference model for dut0 (default parameters)
  int          m_k;
  bit          m_bad;
  logic [31:0] m_frame;
  int          m_err;
  bit          m_de, m_le;
  int          m_streak;

  task automatic model_reset();
    m_k = 0; m_bad = 0; m_frame = 0; m_err = 0;
    m_de = 0; m_le = 0; m_streak = 0;
  endtask

  task automatic model_beat(input logic [31:0] d, input logic [3:0] kp,
                            input logic l);
    logic [31:0] ex;
    bit mis, lb;
    ex  = expd(m_k);
    mis = 0;
    if (m_k < FL) mis = (d != ex) || (kp != 4'hF);
    lb  = l ? (m_k + 1 != FL) : (m_k == FL - 1);
    m_de  = m_de | mis;
    m_le  = m_le | lb;
    m_bad = m_bad | mis | lb;
    if (l) begin
      m_frame = m_frame + 1;
      if (m_bad && m_err < 65535) m_err++;
      if (m_bad) m_streak = 0;
      else if (m_streak < OK) m_streak++;
      m_bad = 0;
      m_k = 0;
    end else begin
      m_k++;
    end
  endtask

  task automatic compare_model();
    chk("rnd_frame", f0, m_frame);
    chk("rnd_err", e0, m_err);
    chk("rnd_data_err", de0, m_de);
    chk("rnd_len_err", le0, m_le);
    chk("rnd_link_ok", l0, (m_streak == OK));
  endtask

  typedef struct {
    int         nb;
    int         flip;
    logic [3:0] lk;
    int         ef;
    int         ee;
    bit         ede;
    bit         ele;
    bit         elok;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[14];
    vt[0]  = '{16, -1, 4'hF,  1, 0, 0, 0, 0};
    vt[1]  = '{16, -1, 4'hF,  2, 0, 0, 0, 0};
    vt[2]  = '{16, -1, 4'hF,  3, 0, 0, 0, 0};
    vt[3]  = '{16, -1, 4'hF,  4, 0, 0, 0, 1};
    vt[4]  = '{16, -1, 4'hF,  5, 0, 0, 0, 1};
    vt[5]  = '{10, -1, 4'hF,  6, 1, 0, 1, 0};
    vt[6]  = '{20, -1, 4'hF,  7, 2, 0, 1, 0};
    vt[7]  = '{16, -1, 4'h7,  8, 3, 1, 1, 0};
    vt[8]  = '{16,  3, 4'hF,  9, 4, 1, 1, 0};
    vt[9]  = '{ 1, -1, 4'hF, 10, 5, 1, 1, 0};
    vt[10] = '{16, -1, 4'hF, 11, 5, 1, 1, 0};
    vt[11] = '{16, -1, 4'hF, 12, 5, 1, 1, 0};
    vt[12] = '{16, -1, 4'hF, 13, 5, 1, 1, 0};
    vt[13] = '{16, -1, 4'hF, 14, 5, 1, 1, 1};

    rst = 1'b0; valid = 1'b0; last = 1'b0; data = '0; keep = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", r0, 0);
    chk("rst_frame", f0, 0);
    chk("rst_err", e0, 0);
    chk("rst_flags", {de0, le0, l0}, 0);
    rst = 1'b1;
    tick();
    chk("ready_after_release", r0, 1);

    for (int i = 0; i < 14; i++) begin
      send_frame(vt[i].nb, vt[i].flip, 32'h0000_0100, vt[i].lk, 0);
      chk($sformatf("tbl%0d_frame", i), f0, vt[i].ef);
      chk($sformatf("tbl%0d_err", i), e0, vt[i].ee);
      chk($sformatf("tbl%0d_data_err", i), de0, vt[i].ede);
      chk($sformatf("tbl%0d_len_err", i), le0, vt[i].ele);
      chk($sformatf("tbl%0d_link_ok", i), l0, vt[i].elok);
    end

    // Reset in the middle of a frame
    for (int k = 0; k < 7; k++) begin
      data = expd(k); keep = 4'hF; last = 1'b0; valid = 1'b1;
      tick();
    end
    data = expd(7);
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst_ready", r0, 0);
    chk("midrst_frame", f0, 0);
    chk("midrst_err", e0, 0);
    chk("midrst_flags", {de0, le0, l0}, 0);
    rst = 1'b1; valid = 1'b0;
    tick();
    chk("midrst_release", {r0, de0, le0, l0}, 4'b1000);
    send_frame(16, -1, 0, 4'hF, 0);
    chk("midrst_frame_after", f0, 1);
    chk("midrst_err_after", e0, 0);
    chk("midrst_flags_after", {de0, le0, l0}, 0);

    // Short frame then long frame
    do_reset();
    send_frame(10, -1, 0, 4'hF, 0);
    chk("short_len_err", le0, 1);
    chk("short_err", e0, 1);
    chk("short_frame", f0, 1);
    for (int k = 0; k < 20; k++) begin
      data = expd(k); keep = 4'hF; last = (k == 19); valid = 1'b1;
      tick();
      if (k >= 15 && k < 19) chk($sformatf("long_hold_b%0d", k + 1), f0, 1);
    end
    valid = 1'b0; last = 1'b0;
    chk("long_frame", f0, 2);
    chk("long_err", e0, 2);
    chk("long_data_err", de0, 0);

    // Partial last-beat keep, single data error
    do_reset();
    send_frame(16, -1, 0, 4'b1000, 1);
    chk("pk_good_err", e1, 0);
    chk("pk_good_flag", de1, 0);
    send_frame(16, 5, 32'h1, 4'b1000, 1);
    chk("pk_data_err", de1, 1);
    chk("pk_err", e1, 1);
    chk("pk_link", l1, 0);
    for (int i = 0; i < 4; i++) send_frame(16, -1, 0, 4'b1000, 1);
    chk("pk_link_back", l1, 1);
    chk("pk_err_final", e1, 1);
    chk("pk_frames", f1, 6);

    // Backpressure
    begin
      int k, nfr, cyc;
      int lastc[3];
      bit er;
      do_reset();
      k = 0; nfr = 0; cyc = 0; er = 1'b1;
      while (nfr < 3 && cyc < 400) begin
        data = expd(k); keep = 4'hF; last = (k == FL - 1); valid = 1'b1;
        chk("bp_ready", r2, er);
        tick();
        cyc++;
        if (er) begin
          if (k == FL - 1) begin
            lastc[nfr] = cyc; nfr++; k = 0;
          end else begin
            k++;
          end
        end
        er = ~er;
      end
      valid = 1'b0; last = 1'b0;
      chk("bp_timeout", nfr, 3);
      if (nfr == 3) begin
        chk("bp_period1", lastc[1] - lastc[0], 2 * FL);
        chk("bp_period2", lastc[2] - lastc[1], 2 * FL);
      end
      chk("bp_frames", f2, 3);
      chk("bp_err", e2, 0);
      chk("bp_flags", {de2, le2}, 0);
    end

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int fr = 0; fr < 60; fr++) begin
      int nb, flip;
      logic [31:0] fm;
      logic [3:0] lk;
      nb   = ($urandom_range(0, 9) < 7) ? FL : int'($urandom_range(1, 20));
      flip = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      fm   = 32'h1 << $urandom_range(0, 31);
      lk   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      for (int k = 0; k < nb; k++) begin
        while ($urandom_range(0, 3) == 0) begin
          valid = 1'b0; data = $urandom; keep = 4'($urandom);
          last = 1'($urandom);
          tick();
          compare_model();
        end
        data = expd(k);
        if (k == flip) data = data ^ fm;
        last  = (k == nb - 1);
        keep  = last ? lk : 4'hF;
        valid = 1'b1;
        tick();
        model_beat(data, keep, last);
        compare_model();
      end
    end
    valid = 1'b0; last = 1'b0;

    // Error counter saturation with back-to-back 1-beat frames
    do_reset();
    data = expd(0); keep = 4'hF; last = 1'b1; valid = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat_err_pre", e0, 16'hFFFE);
    chk("sat_frame_pre", f0, 65534);
    tick();
    chk("sat_err_hit", e0, 16'hFFFF);
    repeat (5) tick();
    chk("sat_err_hold", e0, 16'hFFFF);
    chk("sat_frame", f0, 65540);
    chk("sat_len_err", le0, 1);
    valid = 1'b0; last = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
